// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the instruction-memory loader.
//   - ByteW / WordW     : stream byte width and instruction word width
//   - DefaultDepth      : default instruction-memory capacity in words
//   - loader_state_e    : loader FSM states
// Optional feature: LOADER_CHECKSUM_EN adds the StChk state (checksum byte after data).
package loader_pkg;

  localparam int unsigned ByteW        = 8;
  localparam int unsigned WordW        = 32;
  localparam int unsigned BytesPerWord = WordW / ByteW;
  localparam int unsigned DefaultDepth = 128;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLen0 = 3'd1,
    StLen1 = 3'd2,
    StData = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    StChk  = 3'd4,
`endif
    StDone = 3'd5
  } loader_state_e;

endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles a big-endian 32-bit word from four consecutive bytes.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (discards a partial word)
//   clear_i      : synchronous clear of the accumulator and byte counter
//   byte_valid_i : byte_i is consumed this cycle
//   byte_i       : incoming byte
//   word_o       : packed word, meaningful when word_valid_o is high
//   word_valid_o : the byte consumed this cycle completes a word (combinational pulse)
module byte_packer
  import loader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             byte_valid_i,
  input  logic [ByteW-1:0] byte_i,
  output logic [WordW-1:0] word_o,
  output logic             word_valid_o
);

  localparam int unsigned AccW = WordW - ByteW;

  logic [AccW-1:0] acc_q, acc_d;
  logic [1:0]      cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (byte_valid_i) begin
      // The fourth byte leaves the accumulator empty for the next word.
      if (cnt_q == 2'd3) begin
        acc_d = '0;
      end else begin
        acc_d = {acc_q[AccW-ByteW-1:0], byte_i};
      end
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Earlier bytes sit higher in the word, so the first byte lands in bits 31:24.
  assign word_o       = {acc_q, byte_i};
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: loads a program byte stream into instruction memory while holding the CPU.
// Stream format: 16-bit word count N (high byte first), then 4*N data bytes packed big-endian,
// then (with LOADER_CHECKSUM_EN defined) one checksum byte equal to the XOR of the data bytes.
// Ports:
//   clk, rst            : clock and synchronous active-high reset
//   start               : one-cycle load request, honoured in idle/done only
//   in_data, in_valid   : byte stream input; in_ready accepts it
//   mem_we/addr/wdata   : instruction memory write port, one cycle after the 4th byte of a word
//   cpu_hold            : holds the processor while a load is in progress
//   done                : load finished (level, until next start or rst)
//   len_err             : declared word count exceeded DEPTH
//   chk_err             : checksum mismatch (tied low without LOADER_CHECKSUM_EN)
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned DEPTH     = DefaultDepth,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ByteW-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [WordW-1:0] mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             len_err,
  output logic             chk_err
);

  loader_state_e    state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [WordW-1:0] mem_wdata_q, mem_wdata_d;
  logic             len_err_q, len_err_d;

  logic             xfer;
  logic [15:0]      len_full;
  logic             pk_clear;
  logic             pk_valid;
  logic [WordW-1:0] pk_word;
  logic             pk_word_valid;
  loader_state_e    after_data;

`ifdef LOADER_CHECKSUM_EN
  logic [ByteW-1:0] xor_q, xor_d;
  logic             chk_err_q, chk_err_d;
  assign after_data = StChk;
`else
  assign after_data = StDone;
`endif

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StLen0, StLen1, StData: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StChk:                  in_ready = 1'b1;
`endif
      default:                in_ready = 1'b0;
    endcase
  end

  assign xfer     = in_valid && in_ready;
  assign len_full = {len_q[15:8], in_data};
  assign pk_valid = xfer && (state_q == StData);

  byte_packer u_byte_packer (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    len_err_d   = len_err_q;
    pk_clear    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    xor_d       = xor_q;
    chk_err_d   = chk_err_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLen0;
          len_d      = '0;
          word_cnt_d = '0;
          len_err_d  = 1'b0;
          pk_clear   = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          xor_d      = '0;
          chk_err_d  = 1'b0;
`endif
        end
      end
      StLen0: begin
        if (xfer) begin
          len_d   = {in_data, 8'h00};
          state_d = StLen1;
        end
      end
      StLen1: begin
        if (xfer) begin
          len_d = len_full;
          if (32'(len_full) > DEPTH) begin
            len_err_d = 1'b1;
            state_d   = StDone;
          end else if (len_full == 16'd0) begin
            state_d = after_data;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
`ifdef LOADER_CHECKSUM_EN
        if (xfer) begin
          xor_d = xor_q ^ in_data;
        end
`endif
        if (pk_word_valid) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = BASE_ADDR + 32'({word_cnt_q, 2'b00});
          mem_wdata_d = pk_word;
          word_cnt_d  = word_cnt_q + 16'd1;
          if (word_cnt_q == len_q - 16'd1) begin
            state_d = after_data;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          chk_err_d = (in_data != xor_q);
          state_d   = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      word_cnt_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      len_err_q   <= len_err_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q     <= '0;
      chk_err_q <= 1'b0;
    end else begin
      xor_q     <= xor_d;
      chk_err_q <= chk_err_d;
    end
  end
  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

  // A write registered on the edge before rst must not escape during the reset cycle.
  assign mem_we    = mem_we_q && !rst;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  // The last write lands in the first done cycle, so the hold extends over it.
  assign cpu_hold  = ((state_q != StIdle) && (state_q != StDone)) || mem_we_q;
  assign done      = (state_q == StDone);
  assign len_err   = len_err_q;

endmodule
